// File: rtl/tfe_move_sequencer_if.sv
// Command/status bundle between the 2048 move sequencer and its front end / readout.
// The master drives commands and preloads; the slave (sequencer) returns board and status.
interface tfe_move_sequencer_if #(
    parameter int TILE_W  = 4,
    parameter int SCORE_W = 32
);
    logic                   cmd_valid;
    logic [1:0]             cmd_dir;
    logic                   cmd_ready;
    logic                   restart;
    logic                   load_en;
    logic [16*TILE_W-1:0]   load_board;
    logic [16*TILE_W-1:0]   board_flat;
    logic [SCORE_W-1:0]     score;
    logic                   move_done;
    logic                   moved;
    logic                   won;
    logic                   game_over;

    modport master (
        output cmd_valid, cmd_dir, restart, load_en, load_board,
        input  cmd_ready, board_flat, score, move_done, moved, won, game_over
    );

    modport slave (
        input  cmd_valid, cmd_dir, restart, load_en, load_board,
        output cmd_ready, board_flat, score, move_done, moved, won, game_over
    );
endinterface

// File: rtl/tfe_move_sequencer.sv
// 2048 game controller: owns the 4x4 exponent board, slides/merges one line per cycle
// through a shared datapath, spawns an LFSR-picked tile and evaluates won/game-over.
module tfe_move_sequencer #(
    parameter int          TILE_W    = 4,
    parameter int          SCORE_W   = 32,
    parameter int          WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                 clk,
    input logic                 rst,
    tfe_move_sequencer_if.slave bus
);
    // state   | meaning
    // S_INIT0 | first start-up spawn
    // S_INIT1 | second start-up spawn
    // S_IDLE  | accepting restart / load / move command
    // S_SLIDE | slide+merge line line_q in direction dir_q
    // S_SPAWN | drop one new tile into an empty cell
    // S_CHECK | update won / game_over, pulse move_done after a move
    // S_OVER  | no legal move left, waiting for restart
    typedef enum logic [2:0] {S_INIT0, S_INIT1, S_IDLE, S_SLIDE, S_SPAWN, S_CHECK, S_OVER} state_e;
    typedef logic [TILE_W-1:0] tile_t;

    localparam tile_t           TILE_MAX = '1;
    localparam tile_t           WIN_TILE = tile_t'(WIN_EXP);
    localparam logic [TILE_W:0] SH_ONE   = 1;

    state_e                     state_q, state_d;
    logic [15:0][TILE_W-1:0]    board_q, board_d;
    logic [SCORE_W-1:0]         score_q, score_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [1:0]                 dir_q, dir_d;
    logic [1:0]                 line_q, line_d;
    logic                       changed_q, changed_d;
    logic                       from_move_q, from_move_d;
    logic                       move_done_q, move_done_d;
    logic                       moved_q, moved_d;
    logic                       won_q, won_d;
    logic                       game_over_q, game_over_d;

    tile_t                      line_in  [4];
    tile_t                      line_out [4];
    tile_t                      cmp      [5];
    logic [2:0]                 n_idx;
    logic                       skip;
    logic [SCORE_W-1:0]         merge_gain;
    logic                       line_diff;

    logic [4:0]                 empty_cnt;
    logic [4:0]                 spawn_k;
    logic [4:0]                 seen;
    logic [3:0]                 spawn_idx;
    tile_t                      spawn_val;
    logic                       has_pair;
    logic                       has_win;

    // Element 0 of a line is the cell the tiles slide toward.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] ln,
                                            input logic [1:0] el);
        logic [1:0] rev;
        rev = 2'd3 - el;
        case (dir)
            2'd0:    cell_idx = {el, ln};
            2'd1:    cell_idx = {rev, ln};
            2'd2:    cell_idx = {ln, el};
            default: cell_idx = {ln, rev};
        endcase
    endfunction

    always_comb begin
        for (int e = 0; e < 4; e++) begin
            line_in[2'(e)]  = board_q[cell_idx(dir_q, line_q, 2'(e))];
            line_out[2'(e)] = '0;
        end
        for (int e = 0; e < 5; e++) cmp[3'(e)] = '0;
        n_idx = '0;
        for (int e = 0; e < 4; e++) begin
            if (line_in[2'(e)] != '0) begin
                cmp[n_idx] = line_in[2'(e)];
                n_idx      = n_idx + 3'd1;
            end
        end
        // skip marks the second tile of a merged pair so it cannot merge again
        merge_gain = '0;
        n_idx      = '0;
        skip       = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[3'(e)] != '0) begin
                if (cmp[3'(e)] == cmp[3'(e + 1)]) begin
                    line_out[n_idx[1:0]] = (cmp[3'(e)] == TILE_MAX) ? TILE_MAX
                                                                     : cmp[3'(e)] + tile_t'(1);
                    merge_gain = merge_gain + (SCORE_W'(1) << ({1'b0, cmp[3'(e)]} + SH_ONE));
                    skip       = 1'b1;
                end else begin
                    line_out[n_idx[1:0]] = cmp[3'(e)];
                end
                n_idx = n_idx + 3'd1;
            end
        end
        line_diff = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (line_out[2'(e)] != line_in[2'(e)]) line_diff = 1'b1;
        end
    end

    always_comb begin
        empty_cnt = '0;
        has_win   = 1'b0;
        has_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (board_q[4'(i)] == '0)      empty_cnt = empty_cnt + 5'd1;
            if (board_q[4'(i)] >= WIN_TILE) has_win  = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (c < 3 && board_q[4'(r * 4 + c)] == board_q[4'(r * 4 + c + 1)]) has_pair = 1'b1;
                if (r < 3 && board_q[4'(r * 4 + c)] == board_q[4'(r * 4 + c + 4)]) has_pair = 1'b1;
            end
        end
        // Scale the LFSR byte by the empty count: fixed latency, no rejection loop.
        spawn_k   = 5'(({5'b0, lfsr_q[15:8]} * {8'b0, empty_cnt}) >> 8);
        spawn_idx = '0;
        seen      = '0;
        for (int i = 0; i < 16; i++) begin
            if (board_q[4'(i)] == '0) begin
                if (seen == spawn_k) spawn_idx = 4'(i);
                seen = seen + 5'd1;
            end
        end
        spawn_val = (lfsr_q[7:0] < 8'd26) ? tile_t'(2) : tile_t'(1);
    end

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        score_d     = score_q;
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        dir_d       = dir_q;
        line_d      = line_q;
        changed_d   = changed_q;
        from_move_d = from_move_q;
        move_done_d = 1'b0;
        moved_d     = moved_q;
        won_d       = won_q;
        game_over_d = game_over_q;
        case (state_q)
            S_INIT0: begin
                board_d[spawn_idx] = spawn_val;
                state_d            = S_INIT1;
            end
            S_INIT1: begin
                board_d[spawn_idx] = spawn_val;
                state_d            = S_IDLE;
            end
            S_IDLE: begin
                if (bus.restart) begin
                    board_d     = '0;
                    score_d     = '0;
                    won_d       = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = S_INIT0;
                end else if (bus.load_en) begin
                    board_d     = bus.load_board;
                    from_move_d = 1'b0;
                    state_d     = S_CHECK;
                end else if (bus.cmd_valid) begin
                    dir_d       = bus.cmd_dir;
                    line_d      = '0;
                    changed_d   = 1'b0;
                    from_move_d = 1'b1;
                    state_d     = S_SLIDE;
                end
            end
            S_SLIDE: begin
                for (int e = 0; e < 4; e++) begin
                    board_d[cell_idx(dir_q, line_q, 2'(e))] = line_out[2'(e)];
                end
                score_d   = score_q + merge_gain;
                changed_d = changed_q | line_diff;
                line_d    = line_q + 2'd1;
                if (line_q == 2'd3) state_d = (changed_q | line_diff) ? S_SPAWN : S_CHECK;
            end
            S_SPAWN: begin
                board_d[spawn_idx] = spawn_val;
                state_d            = S_CHECK;
            end
            S_CHECK: begin
                won_d       = won_q | has_win;
                game_over_d = (empty_cnt == 5'd0) && !has_pair;
                if (from_move_q) begin
                    move_done_d = 1'b1;
                    moved_d     = changed_q;
                end
                state_d = game_over_d ? S_OVER : S_IDLE;
            end
            S_OVER: begin
                if (bus.restart) begin
                    board_d     = '0;
                    score_d     = '0;
                    won_d       = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = S_INIT0;
                end
            end
            default: state_d = S_INIT0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT0;
            board_q     <= '0;
            score_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            dir_q       <= '0;
            line_q      <= '0;
            changed_q   <= 1'b0;
            from_move_q <= 1'b0;
            move_done_q <= 1'b0;
            moved_q     <= 1'b0;
            won_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            score_q     <= score_d;
            lfsr_q      <= lfsr_d;
            dir_q       <= dir_d;
            line_q      <= line_d;
            changed_q   <= changed_d;
            from_move_q <= from_move_d;
            move_done_q <= move_done_d;
            moved_q     <= moved_d;
            won_q       <= won_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.board_flat = board_q;
    assign bus.score      = score_q;
    assign bus.move_done  = move_done_q;
    assign bus.moved      = moved_q;
    assign bus.won        = won_q;
    assign bus.game_over  = game_over_q;
endmodule

// File: doc/tfe_move_sequencer.md
Name: tfe_move_sequencer

Overview:
- Game controller for the 2048 board: owns the 4x4 tile array and accepts one move command at a time.
- Sequences slide/merge one line per cycle through a single shared line datapath, then spawns a random tile with an LFSR-driven empty-cell pick (fixed latency, no retry loop).
- Finally evaluates won/game-over status.
- Sits between the joystick/debouncer front end and the UART/display readout.

Parameters:
- TILE_W, 4: tile width. Tiles hold log2 exponents: 0 = empty, e = value 2^e.
- SCORE_W, 32: score accumulator width.
- WIN_EXP, 11: exponent that sets won (2048).
- LFSR_SEED, 16'hACE1: nonzero reset seed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  move request.
- cmd_dir  in  2  0 = up, 1 = down, 2 = left, 3 = right.
- cmd_ready  out  1  high only in IDLE.
- restart  in  1  clears the game; honoured in IDLE or OVER.
- load_en  in  1  test preload; honoured in IDLE only.
- load_board  in  16*TILE_W  preload image.
- board_flat  out  16*TILE_W  cell r*4+c at bits [(r*4+c)*TILE_W +: TILE_W].
- score  out  SCORE_W  running score.
- move_done  out  1  one-cycle pulse at end of each command.
- moved  out  1  board changed by last command; valid with move_done, held until next done.
- won  out  1  some tile >= WIN_EXP; sticky until restart/reset.
- game_over  out  1  no legal move remains.

Behaviour:
- Reset (rst=0):
  - board, score, move_done, moved, won, game_over all = 0.
  - LFSR = LFSR_SEED; state = INIT0.
  - Takes effect immediately, including mid-SLIDE/SPAWN. Partial moves are discarded.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle outside reset.
- States: INIT0, INIT1, IDLE, SLIDE, SPAWN, CHECK, OVER.
- INIT0, INIT1: each performs a spawn (rules below), one cycle each, then IDLE. cmd_ready = 0.
- IDLE, priority restart > load_en > cmd.
  - restart: clear board and score, clear won/game_over, go to INIT0.
  - load_en: board = load_board, score unchanged, go to CHECK. Load does not pulse move_done.
  - cmd_valid & cmd_ready: latch dir, line index = 0, changed = 0, go to SLIDE.
- SLIDE, 4 cycles, lines 0..3:
  - left: row i, element 0 = col 0. right: row i, element 0 = col 3.
  - up: column i, element 0 = row 0. down: column i, element 0 = row 3.
  - Compact nonzero tiles toward element 0.
  - Merge equal adjacent pairs scanning from element 0. Each tile merges at most once per move, so [1,1,1,1] gives [2,2,0,0], not [3,0,0,0].
  - Merged exponent = e+1, saturating at 2^TILE_W-1.
  - score += 2^(e+1) per merge, wrapping modulo 2^SCORE_W.
  - Write the line back. changed |= (line differs).
  - After line 3: go to SPAWN if changed, else CHECK.
- SPAWN, 1 cycle:
  - E = number of empty cells (>=1, guaranteed).
  - k = (lfsr[15:8] * E) >> 8.
  - Target = k-th empty cell in index order 0..15.
  - Value: exponent 2 if lfsr[7:0] < 26, else exponent 1.
  - Go to CHECK.
- CHECK, 1 cycle:
  - won |= any tile >= WIN_EXP.
  - game_over = no empty cell AND no horizontally/vertically adjacent equal pair.
  - If entered from a move: move_done = 1 for the next cycle, moved = changed.
  - Go to OVER if game_over, else IDLE.
- OVER: cmd_ready = 0. Commands and load_en are ignored. Only restart or reset exits.
- Latency, handshake sampled at edge T:
  - moved: lines written at edges T+1..T+4, spawn at T+5, flags at T+6. move_done is high in the cycle after T+6; cmd_ready returns in that same cycle.
  - unmoved: flags at T+5, move_done high in the cycle after T+5.
- cmd_valid outside IDLE is ignored; no queueing.
- Only the single shared slide/merge datapath is used; no four-line-parallel merge.

Test Plan:
- Power-up: hold rst=0 for 3 cycles, release → board all 0 during reset; 2 cycles after release exactly two nonzero cells, each exponent 1 or 2; cmd_ready=1; score=0.
- Merge and score: load row0=[1,1,2,2], rest 0; cmd left → row0=[2,3,0,0]; score=12; moved=1; move_done one cycle after edge T+6; exactly one new tile in rows 1–3 or row0 cols 2–3.
- Single-merge rule: load row0=[1,1,1,1] → left gives [2,2,0,0], score +8. Load row0=[1,1,2,0] → left gives [2,2,0,0], not [3,0,0,0].
- No-op move: load rows packed left with no equal neighbours; cmd left → board bit-identical; moved=0; no spawn; move_done one cycle after T+5.
- Game over: load checkerboard alternating exponents 1/2 → after CHECK, game_over=1 and cmd_ready=0; cmd_valid ignored for 10 cycles; restart → INIT0, board clears, then two spawned tiles appear.
- Win and async reset: load cells 0,1 = 10,10; left → cell0=11, won=1, game continues. Assert rst mid-SLIDE → all outputs 0 immediately, board cleared, INIT0 sequence runs after release.
